// File: rtl/multicycle_addsub.sv
// Multi-cycle add/subtract: resolves the carry chain SLICE bits per clock, LSB slice first.
// Latency NSLICE+1 cycles handshake-to-out_valid; holds in DONE while out_ready is low.
// Build option: define MULTICYCLE_ADDSUB_FLAGS_EN to compute ovf/zero (otherwise tied to 0).
module multicycle_addsub #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SAFE_SLICE = (SLICE < 1) ? 1 : SLICE;
    localparam int NSLICE     = WIDTH / SAFE_SLICE;
    localparam int CW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((SLICE < 1) || ((WIDTH % SAFE_SLICE) != 0)) begin : g_bad_param
            $error("multicycle_addsub: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [31:0]      base_idx;
    logic [SLICE:0]   slice_res;
    logic [WIDTH-1:0] sum_d;
    logic             last_slice;
    logic             accept;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == DONE);
    assign accept     = in_valid && in_ready;
    assign last_slice = (cnt_q == CW'(NSLICE - 1));

    // One slice of the ripple: slice cnt_q of a and bx plus the running carry.
    always_comb begin
        base_idx  = 32'(cnt_q) * 32'(SLICE);
        slice_res = {1'b0, a_q[base_idx +: SLICE]}
                  + {1'b0, bx_q[base_idx +: SLICE]}
                  + {{SLICE{1'b0}}, carry_q};
        sum_d     = sum;
        sum_d[base_idx +: SLICE] = slice_res[SLICE-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            bx_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        bx_q    <= op ? ~b : b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sum     <= sum_d;
                    carry_q <= slice_res[SLICE];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_slice) begin
                        cout <= slice_res[SLICE];
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MULTICYCLE_ADDSUB_FLAGS_EN
    // Flags use the fully assembled sum so they update in the same edge as the last slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if ((state_q == RUN) && last_slice) begin
            ovf  <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            zero <= (sum_d == '0);
        end
    end
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: 32/8 instance for function and timing, 64/64 instance for NSLICE=1.
module tb_multicycle_addsub;

`ifdef MULTICYCLE_ADDSUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;
    logic        in_valid_w, in_ready_w, cin_w, op_w, out_valid_w, out_ready_w, cout_w, ovf_w, zero_w;
    logic [63:0] a_w, b_w, sum_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_addsub #(.WIDTH(32), .SLICE(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    multicycle_addsub #(.WIDTH(64), .SLICE(64)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .cin(cin_w), .op(op_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .sum(sum_w), .cout(cout_w), .ovf(ovf_w), .zero(zero_w)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        op;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on a - b - 1 + cin or a + b + cin.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mcin, input logic mop,
                         output logic [31:0] es, output logic ec, output logic eo, output logic ez);
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (mop) begin
            ur = ua + (64'hFFFF_FFFF - ub) + longint'(mcin);
            sr = sa - sb - 1 + longint'(mcin);
        end else begin
            ur = ua + ub + longint'(mcin);
            sr = sa + sb + longint'(mcin);
        end
        es = ur[31:0];
        ec = (ur >= 64'h1_0000_0000);
        eo = FLAGS && ((sr > 64'sd2147483647) || (sr < -64'sd2147483648));
        ez = FLAGS && (ur[31:0] == 32'd0);
    endtask

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin, input logic top,
                         input int hold, output logic [31:0] rs, output logic rc, output logic ro,
                         output logic rz);
        int          cyc;
        logic [31:0] s0;
        logic        c0;
        a = ta; b = tb_; cin = tcin; op = top; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); op = 1'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            chk("in_ready_busy", in_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, 5);
        rs = sum; rc = cout; ro = ovf; rz = zero;
        s0 = sum; c0 = cout;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_sum", sum, s0);
            chk("bp_cout", cout, c0);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_rise", in_ready, 1);
    endtask

    initial begin
        logic [31:0] rs, es;
        logic        rc, ro, rz, ec, eo, ez, seen;
        logic [31:0] ra, rb;
        logic        rcin, rop;
        int          cyc;
        logic [64:0] wfull;

        tbl[0] = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h0000ABCD, 32'h0000ABCD, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b0;
        in_valid_w = 1'b0; a_w = '0; b_w = '0; cin_w = 1'b0; op_w = 1'b0; out_ready_w = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);

        // in_valid together with rst must not start an operation
        in_valid = 1'b1; a = 32'h1; b = 32'h1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst_valid_not_accepted", seen, 0);
        chk("in_ready_after_rst", in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].op, (i == 0) ? 10 : 0, rs, rc, ro, rz);
            chk("tbl_sum", rs, tbl[i].s);
            chk("tbl_cout", rc, tbl[i].c);
            chk("tbl_ovf", ro, tbl[i].o & FLAGS);
            chk("tbl_zero", rz, tbl[i].z & FLAGS);
        end

        for (int i = 0; i < 30; i++) begin
            ra = $urandom; rb = (i % 7 == 0) ? ra : $urandom;
            rcin = 1'($urandom); rop = 1'($urandom);
            model(ra, rb, rcin, rop, es, ec, eo, ez);
            do_op(ra, rb, rcin, rop, $urandom_range(0, 3), rs, rc, ro, rz);
            chk("rnd_sum", rs, es);
            chk("rnd_cout", rc, ec);
            chk("rnd_ovf", ro, eo);
            chk("rnd_zero", rz, ez);
        end

        // Reset in the second RUN cycle aborts the operation
        a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_zero", zero, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_in_ready_back", in_ready, 1);
        model(32'h00C0FFEE, 32'h11111111, 1'b0, 1'b0, es, ec, eo, ez);
        do_op(32'h00C0FFEE, 32'h11111111, 1'b0, 1'b0, 0, rs, rc, ro, rz);
        chk("post_abort_sum", rs, es);
        chk("post_abort_cout", rc, ec);

        // WIDTH=64, SLICE=64: single-slice, out_valid in cycle 2
        a_w = {$urandom, $urandom}; b_w = 64'hFFFF_FFFF_FFFF_FFFF; cin_w = 1'b1; op_w = 1'b0;
        wfull = {1'b0, a_w} + {1'b0, b_w} + 65'(cin_w);
        chk("w_in_ready", in_ready_w, 1);
        in_valid_w = 1'b1;
        @(posedge clk); #1;
        in_valid_w = 1'b0; a_w = '0; b_w = '0;
        cyc = 1;
        while (!out_valid_w && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w_latency", cyc, 2);
        chk("w_sum", sum_w, wfull[63:0]);
        chk("w_cout", cout_w, wfull[64]);
        out_ready_w = 1'b1;
        @(posedge clk); #1;
        out_ready_w = 1'b0;
        chk("w_out_valid_drop", out_valid_w, 0);
        chk("w_in_ready_rise", in_ready_w, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_addsub.md
# multicycle_addsub

Parametrised, multi-cycle add/subtract unit for the ALU datapath. It accepts WIDTH-bit operands through a valid/ready handshake and resolves the carry chain one SLICE-bit slice per clock, LSB slice first. It returns sum, carry and optional status flags through a second valid/ready handshake. It generalises the single-cycle 32-bit add-with-carry to arbitrary widths and adds subtraction, flags and backpressure.

## Interface
Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 16, bits resolved per clock; NSLICE = WIDTH/SLICE. SLICE == WIDTH is legal (NSLICE = 1).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- op  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH-1 (1 = no borrow when subtracting).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Effective operand: bx = op ? ~b : b. The result is a + bx + cin, modulo 2^WIDTH. Plain subtract uses op=1 with cin=1. Subtract-with-borrow passes the previous cout as cin.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready = 1. On in_valid && in_ready, latch a, bx and cin, clear the slice counter, and go to RUN.
- RUN: each cycle, add slice k of a and bx plus the running carry. Write the result into sum[k*SLICE +: SLICE] and register the slice carry-out. After slice NSLICE-1, go to DONE.
- DONE: out_valid = 1. sum, cout, ovf and zero stay stable until out_valid && out_ready, then the FSM goes to IDLE.
- cout is the carry out of the final slice.
- ovf = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]).
- zero = (sum == 0).
- Operand inputs are ignored outside the IDLE handshake. Changing a or b during RUN has no effect.
- A WIDTH that is not a multiple of SLICE, or a SLICE of less than 1, is an elaboration-time error.

## Timing
- Cycle 0: handshake edge. Cycles 1..NSLICE: RUN. out_valid rises in cycle NSLICE+1 (cycle 5 with defaults).
- out_valid drops the cycle after the output handshake. in_ready rises in that same cycle.
- Best-case throughput is one operation per NSLICE+2 cycles. There is no overlap: in_ready = 0 in RUN and DONE.
- With out_ready held low, DONE persists indefinitely and outputs do not change.
- Reset values: in_ready 0 while rst is high, then 1. out_valid 0. sum, cout, ovf and zero are 0.
- Reset during RUN or DONE aborts the operation. No out_valid is produced, and the state returns to IDLE on the next edge.
- If in_valid and rst are high together, the operation is not accepted.
- Outputs are registered only. There is no combinational path from in_valid or out_ready to any output except through the state registers.

## Configuration
- MULTICYCLE_ADDSUB_FLAGS_EN defined: ovf and zero are computed as described above and registered with sum.
- Not defined: the ovf and zero ports remain but are tied to 0. The flag logic is not synthesised. sum, cout and latency are unchanged.

## Test plan
All cases use WIDTH=32 and SLICE=8 (NSLICE=4) unless stated otherwise.
- Add, no carry: a=12345678, b=87654321, cin=0, op=0 -> sum=99999999, cout=0, ovf=0, zero=0. out_valid rises exactly 5 cycles after the handshake.
- Carry ripple across all slices: a=FFFFFFFF, b=00000001, cin=1, op=0 -> sum=00000001, cout=1, ovf=0.
- Subtract and zero flag: a=00000005, b=00000007, op=1, cin=1 -> sum=FFFFFFFE, cout=0. Then a=b=0000ABCD, op=1, cin=1 -> sum=0, cout=1, zero=1 (flags enabled).
- Signed overflow: a=7FFFFFFF, b=00000001, cin=0, op=0 -> sum=80000000, ovf=1. With MULTICYCLE_ADDSUB_FLAGS_EN undefined -> ovf=0, sum unchanged.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Outputs must stay stable and in_ready must stay 0. Release out_ready; in_ready rises in the following cycle. Also run WIDTH=64, SLICE=64 and check out_valid in cycle 2.
- Reset mid-operation: assert rst in cycle 2 of RUN -> out_valid never rises, and all outputs read 0. After rst drops, in_ready=1 and a new add completes normally.
